// File: rtl/tensor_core_scheduler_if.sv
// Requester/consumer handshake bundle for the tensor core scheduler.
// The master side issues job requests and consumes responses; the slave side is the scheduler.
interface tensor_core_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ack;
    logic               resp_valid;
    logic [ID_W-1:0]    resp_id;
    logic               resp_error;
    logic               resp_ready;

    modport master (
        output req_valid, resp_ready,
        input  req_ack, resp_valid, resp_id, resp_error
    );

    modport slave (
        input  req_valid, resp_ready,
        output req_ack, resp_valid, resp_id, resp_error
    );
endinterface

// File: rtl/tensor_core_scheduler.sv
// Round-robin scheduler sharing one 4x4 int8 tensor core among NUM_REQ requesters.
// Per job: steer operands, pulse load, pulse start, wait for done (with timeout), return a response.
module tensor_core_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic                     clock_in,
    input  logic                     reset_n_in,
    tensor_core_scheduler_if.slave   bus,
    output logic [ID_W-1:0]          operand_sel,
    output logic                     tc_write_enable,
    output logic                     tc_start,
    input  logic                     tc_done,
    output logic                     busy,
    output logic [CNT_W-1:0]         job_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    logic [2:0]      state;
    logic [ID_W-1:0] last_grant;
    logic [TO_W-1:0] timeout_cnt;
    logic [ID_W-1:0] winner;
    logic            winner_found;
    logic [ID_W-1:0] cand;

    // Pick the first requesting index after last_grant, wrapping modulo NUM_REQ.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        winner       = '0;
        winner_found = 1'b0;
        cand         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!winner_found && bus.req_valid[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    // Job sequencing, timeout counting and registered response/grant state.
    always_ff @(posedge clock_in) begin
        // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
        if (!reset_n_in) begin
            state          <= S_IDLE;
            last_grant     <= ID_W'(NUM_REQ - 1);
            operand_sel    <= '0;
            timeout_cnt    <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_id    <= '0;
            bus.resp_error <= 1'b0;
            job_count      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (winner_found) begin
                        operand_sel <= winner;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_START;
                end
                S_START: begin
                    timeout_cnt <= '0;
                    state       <= S_RUN;
                end
                S_RUN: begin
                    // Done takes priority over a timeout landing in the same cycle.
                    if (tc_done) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_id    <= operand_sel;
                        bus.resp_error <= 1'b0;
                        state          <= S_RESP;
                    end else if (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        bus.resp_valid <= 1'b1;
                        bus.resp_id    <= operand_sel;
                        bus.resp_error <= 1'b1;
                        state          <= S_RESP;
                    end else begin
                        timeout_cnt <= timeout_cnt + TO_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.resp_id    <= '0;
                        bus.resp_error <= 1'b0;
                        last_grant     <= operand_sel;
                        job_count      <= job_count + CNT_W'(1);
                        state          <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes and ack are pure decodes of state; the ack targets the registered winner.
    assign bus.req_ack     = (state == S_LOAD) ? (NUM_REQ'(1) << operand_sel) : '0;
    assign tc_write_enable = (state == S_LOAD);
    assign tc_start        = (state == S_START);
    assign busy            = (state != S_IDLE);

endmodule
